march_step_accum: RTL

- Sequential ray-march accumulator sitting directly downstream of step3vec, which it instantiates and whose step vector it consumes.
- On start it latches a ray origin and direction. Each cycle it samples the signed distance d_in from the external SDF stage, which is driven combinationally from this block's position outputs, and adds the approximate step d·dir>>14 to the position.
- It terminates on a hit (|d| below threshold) or when the iteration budget is exhausted, then reports hit and iteration count to the shading stage.

---
 rtl/march_step_accum.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/march_step_accum.sv
// Purpose: ray-march accumulator; steps (px,py,pz) along a latched direction by an SDF-scaled step.
// Latency: start edge, then up to MAX_ITERS MARCH cycles, then one FIN cycle with done; no stall path.
// Backpressure: none; start is ignored while busy and d_in is consumed on every MARCH edge.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             begin a ray (accepted only in IDLE)
//   ox/oy/oz          signed ray origin
//   dx/dy/dz          signed unit direction (1.0 = 16384)
//   d_in              signed 11-bit SDF distance at the current position, same-cycle valid
//   px/py/pz          registered march position
//   busy, done        busy = not IDLE; done = single-cycle completion pulse
//   hit, iter_count   result and number of position updates for the current/last ray

// step3vec: shift-only approximation of d*dir>>14 for a 3-component direction.
// The leading-one position of |d| picks the shift, so the step is dir scaled by
// the largest power of two not exceeding |d|. Negative d uses one's complement
// for both the magnitude and the direction, matching the sign convention of d_in.
module step3vec (
  input  logic signed [10:0] d,
  input  logic signed [15:0] xin,
  input  logic signed [15:0] yin,
  input  logic signed [15:0] zin,
  output logic signed [15:0] xout,
  output logic signed [15:0] yout,
  output logic signed [15:0] zout
);

  logic              neg;
  logic [9:0]        dabs;
  logic [3:0]        msb;
  logic [3:0]        sh;
  logic signed [15:0] xc, yc, zc;

  always_comb begin
    neg  = d[10];
    dabs = neg ? ~d[9:0] : d[9:0];
    msb  = '0;
    for (int i = 0; i < 10; i++) begin
      if (dabs[i]) msb = 4'(i);
    end
    // dir * 2^msb >> 14 collapses into a single right shift of 14-msb (5..14).
    sh = 4'd14 - msb;
    xc = neg ? ~xin : xin;
    yc = neg ? ~yin : yin;
    zc = neg ? ~zin : zin;
    if (dabs == 10'd0) begin
      xout = '0;
      yout = '0;
      zout = '0;
    end else begin
      xout = xc >>> sh;
      yout = yc >>> sh;
      zout = zc >>> sh;
    end
  end

endmodule

module march_step_accum #(
  parameter int MAX_ITERS  = 8,
  parameter int HIT_THRESH = 4,
  parameter int ITER_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [15:0]       ox,
  input  logic signed [15:0]       oy,
  input  logic signed [15:0]       oz,
  input  logic signed [15:0]       dx,
  input  logic signed [15:0]       dy,
  input  logic signed [15:0]       dz,
  input  logic signed [10:0]       d_in,
  output logic signed [15:0]       px,
  output logic signed [15:0]       py,
  output logic signed [15:0]       pz,
  output logic                     busy,
  output logic                     done,
  output logic                     hit,
  output logic [ITER_W-1:0]        iter_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARCH = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [ITER_W-1:0] MAX_I  = ITER_W'(MAX_ITERS);
  localparam logic [9:0]        THRESH = 10'(HIT_THRESH);

  state_t             state_q, state_d;
  logic signed [15:0] px_q, py_q, pz_q, px_d, py_d, pz_d;
  logic signed [15:0] dirx_q, diry_q, dirz_q, dirx_d, diry_d, dirz_d;
  logic [ITER_W-1:0]  iter_q, iter_d, iter_inc;
  logic               hit_q, hit_d;

  logic [9:0]         dabs;
  logic               is_hit;
  logic signed [15:0] stx, sty, stz;

  step3vec u_step (
    .d    (d_in),
    .xin  (dirx_q),
    .yin  (diry_q),
    .zin  (dirz_q),
    .xout (stx),
    .yout (sty),
    .zout (stz)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= '0;
      dirx_q  <= '0;
      diry_q  <= '0;
      dirz_q  <= '0;
      iter_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      dirz_q  <= dirz_d;
      iter_q  <= iter_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    dabs     = d_in[10] ? ~d_in[9:0] : d_in[9:0];
    is_hit   = (dabs < THRESH);
    iter_inc = iter_q + ITER_W'(1);

    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    pz_d    = pz_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    dirz_d  = dirz_q;
    iter_d  = iter_q;
    hit_d   = hit_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          px_d    = ox;
          py_d    = oy;
          pz_d    = oz;
          dirx_d  = dx;
          diry_d  = dy;
          dirz_d  = dz;
          iter_d  = '0;
          hit_d   = 1'b0;
          state_d = MARCH;
        end
      end
      MARCH: begin
        // A hit freezes the position even when the budget is also spent.
        if (is_hit) begin
          hit_d   = 1'b1;
          state_d = FIN;
        end else begin
          px_d   = px_q + stx;
          py_d   = py_q + sty;
          pz_d   = pz_q + stz;
          iter_d = iter_inc;
          if (iter_inc == MAX_I) begin
            hit_d   = 1'b0;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == FIN);
    px         = px_q;
    py         = py_q;
    pz         = pz_q;
    hit        = hit_q;
    iter_count = iter_q;
  end

endmodule
